sdram_pll_reset_sequencer: RTL
==============================

# sdram_pll_reset_sequencer

Reset/lock sequencer for the SDRAM system PLL. It runs on the free-running 50 MHz reference clock and drives the PLL reset. It qualifies the PLL lock output and holds the SDRAM/Nios II clock-domain reset until lock is stable. It recovers automatically from lock loss or lock timeout, and provides a relock request/acknowledge handshake and failure status to software.

## Interface
Parameters:
- RST_PULSE_CYCLES, 16, cycles pll_rst is held high per reset attempt (≥2)
- LOCK_TIMEOUT_CYCLES, 50000, maximum cycles in WAIT_LOCK before retry
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required
- RELEASE_DELAY_CYCLES, 64, extra cycles after stable lock before sys_reset_n deasserts
- MAX_RETRIES, 4, timeout attempts before FAIL (≥1)
- CNT_W, 16, width of the shared cycle counter; must hold every *_CYCLES value

Ports:
- clk  in  1  reference clock (50 MHz, same net as PLL refclk)
- reset_n  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL locked, asynchronous to clk
- relock_req  in  1  single-cycle relock request pulse
- pll_rst  out  1  PLL reset, active-high
- sys_reset_n  out  1  downstream reset, active-low; downstream domains re-synchronize it
- ready  out  1  high only in RUN
- fail  out  1  high only in FAIL
- relock_ack  out  1  one-cycle pulse when a pending request completes
- retry_cnt  out  3  timeout retries in the current attempt sequence
- lock_loss_cnt  out  8  saturating count of lock losses in RUN
- state  out  3  debug: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAIL=5

## Operation
- Reset values: state=RESET_PLL, cnt=0, pll_rst=1, sys_reset_n=0, ready=0, fail=0, relock_ack=0, retry_cnt=0, lock_loss_cnt=0, pending=0, sync flops=0.
- pll_locked passes through a two-flop synchronizer to produce locked_s. Only locked_s is used.
- RESET_PLL: pll_rst=1, cnt increments. When cnt==RST_PULSE_CYCLES-1, go to WAIT_LOCK with cnt=0.
- WAIT_LOCK: pll_rst=0.
  - locked_s=1: go to STABLE, cnt=0.
  - Otherwise, when cnt==LOCK_TIMEOUT_CYCLES-1: if retry_cnt==MAX_RETRIES-1, go to FAIL; else retry_cnt++ and go to RESET_PLL.
- STABLE: each cycle with locked_s=1 increments cnt.
  - When cnt==LOCK_STABLE_CYCLES-1, go to RELEASE with cnt=0.
  - locked_s=0 returns to WAIT_LOCK with cnt=0. The timeout window restarts and retry_cnt is unchanged.
- RELEASE: same counting against RELEASE_DELAY_CYCLES, then go to RUN.
  - locked_s=0 goes to RESET_PLL. retry_cnt is unchanged.
- RUN: sys_reset_n=1, ready=1, retry_cnt cleared on entry. If pending=1 on entry, pulse relock_ack and clear pending.
  - locked_s=0: lock_loss_cnt++ (saturates at 255), go to RESET_PLL.
  - relock_req=1 with locked_s=1: pending=1, go to RESET_PLL.
  - Both in the same cycle: treat as lock loss, but also set pending.
- FAIL: pll_rst=1, fail=1, terminal.
  - Exit only via reset_n, or via relock_req, which clears retry_cnt, sets pending and goes to RESET_PLL.
- relock_req is ignored outside RUN/FAIL. There is no queuing beyond the single pending flag.
- All outputs are registered and decoded from the next-state value, so they change on the same edge as state. sys_reset_n=0 in every state except RUN.

## Timing
- Synchronizer latency: 2 edges.
- pll_rst pulse is exactly RST_PULSE_CYCLES cycles per attempt. The first is the first edge after reset_n deasserts.
- Lock-to-release latency: sys_reset_n rises on edge E(2+LOCK_STABLE_CYCLES+RELEASE_DELAY_CYCLES). E0 is the edge on which the synchronizer first samples pll_locked=1 in WAIT_LOCK.
- Lock loss in RUN: sys_reset_n falls on the edge after locked_s falls, which is 3 edges after pll_locked falls.
- Asynchronous reset_n assertion mid-sequence: all outputs return to reset values immediately, with no glitch on sys_reset_n (already 0 or forced 0).

## Test plan
Bench parameters: RST_PULSE=4, TIMEOUT=32, STABLE=8, RELEASE=4, MAX_RETRIES=2.

- **Nominal bring-up:** pll_locked rises 10 cycles after reset_n -> pll_rst high for cycles 0–3, sys_reset_n and ready rise 14 edges after first sample, retry_cnt=0, relock_ack never pulses.
- **Lock glitch in STABLE:** pll_locked low for 1 cycle at STABLE cnt=5 -> return to WAIT_LOCK, full 8-cycle stability recount, sys_reset_n still 0 throughout.
- **Timeout and fail:** pll_locked held 0 -> 32-cycle WAIT_LOCK, retry_cnt=1, second 4-cycle pll_rst pulse, second timeout enters FAIL with fail=1 and pll_rst=1. A relock_req pulse then restarts with retry_cnt=0.
- **Lock loss in RUN:** drop pll_locked -> sys_reset_n=0 three edges later, lock_loss_cnt=1, full resequence. 256 losses leave lock_loss_cnt=255.
- **Relock handshake:** relock_req pulse in RUN -> RESET_PLL next edge, relock_ack exactly one cycle on re-entry to RUN. relock_req coincident with lock loss -> lock_loss_cnt++ and ack still delivered.
- **Reset mid-RELEASE:** assert reset_n -> all outputs at reset values immediately, sequence restarts from RESET_PLL.

Source files
------------

// File: rtl/sdram_pll_reset_sequencer.sv
// sdram_pll_reset_sequencer
// Drives the SDRAM system PLL reset from the 50 MHz reference clock.
// Qualifies PLL lock and holds the downstream reset until lock is stable.
// Retries automatically on lock loss or lock timeout.
// Offers software a relock request/acknowledge handshake and failure status.
module sdram_pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES  = 50000,
    parameter int LOCK_STABLE_CYCLES   = 1024,
    parameter int RELEASE_DELAY_CYCLES = 64,
    parameter int MAX_RETRIES          = 4,
    parameter int CNT_W                = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       ready,
    output logic       fail,
    output logic       relock_ack,
    output logic [2:0] retry_cnt,
    output logic [7:0] lock_loss_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    // Terminal counts: the shared counter starts at 0 in each state.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_DELAY_CYCLES - 1);
    localparam logic [2:0]       RETRY_LAST   = 3'(MAX_RETRIES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sync_q, sync_d;
    logic [2:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             pending_q, pending_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_reset_n_q, sys_reset_n_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;
    logic             ack_q, ack_d;
    logic             locked_s;
    logic             run_entry;

    // Only the second synchronizer stage may be looked at by the FSM.
    assign locked_s = sync_q[1];

    // Next-state, counter, bookkeeping and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        loss_d    = loss_q;
        pending_d = pending_q;
        sync_d    = {sync_q[0], pll_locked};

        case (state_q)
            ST_RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_q == RETRY_LAST) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = retry_q + 3'd1;
                        state_d = ST_RESET_PLL;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!locked_s) begin
                    state_d = ST_RESET_PLL;
                    cnt_d   = '0;
                end else if (cnt_q == RELEASE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d = ST_RESET_PLL;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                    if (relock_req) begin
                        pending_d = 1'b1;
                    end
                end else if (relock_req) begin
                    state_d   = ST_RESET_PLL;
                    pending_d = 1'b1;
                end
            end
            ST_FAIL: begin
                cnt_d = '0;
                if (relock_req) begin
                    state_d   = ST_RESET_PLL;
                    retry_d   = '0;
                    pending_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RESET_PLL;
                cnt_d   = '0;
            end
        endcase

        // Entering RUN completes the attempt sequence and any pending relock.
        run_entry = (state_d == ST_RUN) && (state_q != ST_RUN);
        ack_d     = run_entry && pending_q;
        if (run_entry) begin
            retry_d   = '0;
            pending_d = 1'b0;
        end

        pll_rst_d     = (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
        sys_reset_n_d = (state_d == ST_RUN);
        ready_d       = (state_d == ST_RUN);
        fail_d        = (state_d == ST_FAIL);
    end

    // State, counters, synchronizer and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RESET_PLL;
            cnt_q         <= '0;
            sync_q        <= '0;
            retry_q       <= '0;
            loss_q        <= '0;
            pending_q     <= 1'b0;
            pll_rst_q     <= 1'b1;
            sys_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
            fail_q        <= 1'b0;
            ack_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sync_q        <= sync_d;
            retry_q       <= retry_d;
            loss_q        <= loss_d;
            pending_q     <= pending_d;
            pll_rst_q     <= pll_rst_d;
            sys_reset_n_q <= sys_reset_n_d;
            ready_q       <= ready_d;
            fail_q        <= fail_d;
            ack_q         <= ack_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sys_reset_n   = sys_reset_n_q;
    assign ready         = ready_q;
    assign fail          = fail_q;
    assign relock_ack    = ack_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;
    assign state         = state_q;

endmodule
